// File: rtl/axi_read_router.sv
// Two-master, three-slave AXI read router: round-robin AR arbitration, address decode
// to S0/S1/default S2, and R-burst return to the granted master, one transaction at a time.
module axi_read_router #(
    parameter int                ADDR_W  = 32,
    parameter int                DATA_W  = 32,
    parameter int                IDM_W   = 4,
    parameter int                IDS_W   = 8,
    parameter int                LEN_W   = 4,
    parameter logic [ADDR_W-1:0] S0_BASE = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] S0_MASK = 32'hFFFF_0000,
    parameter logic [ADDR_W-1:0] S1_BASE = 32'h0001_0000,
    parameter logic [ADDR_W-1:0] S1_MASK = 32'hFFFF_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2*IDM_W-1:0]  ARID_M,
    input  logic [2*ADDR_W-1:0] ARADDR_M,
    input  logic [2*LEN_W-1:0]  ARLEN_M,
    input  logic [2*3-1:0]      ARSIZE_M,
    input  logic [2*2-1:0]      ARBURST_M,
    input  logic [1:0]          ARVALID_M,
    output logic [1:0]          ARREADY_M,
    output logic [2*IDM_W-1:0]  RID_M,
    output logic [2*DATA_W-1:0] RDATA_M,
    output logic [2*2-1:0]      RRESP_M,
    output logic [1:0]          RLAST_M,
    output logic [1:0]          RVALID_M,
    input  logic [1:0]          RREADY_M,
    output logic [IDS_W-1:0]    ARID_S,
    output logic [ADDR_W-1:0]   ARADDR_S,
    output logic [LEN_W-1:0]    ARLEN_S,
    output logic [2:0]          ARSIZE_S,
    output logic [1:0]          ARBURST_S,
    output logic [2:0]          ARVALID_S,
    input  logic [2:0]          ARREADY_S,
    input  logic [3*IDS_W-1:0]  RID_S,
    input  logic [3*DATA_W-1:0] RDATA_S,
    input  logic [3*2-1:0]      RRESP_S,
    input  logic [2:0]          RLAST_S,
    input  logic [2:0]          RVALID_S,
    output logic [2:0]          RREADY_S,
    output logic [1:0]          o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_ptr;
    logic                r_win;
    logic [1:0]          r_sel;
    logic [IDS_W-1:0]    r_arid;
    logic [ADDR_W-1:0]   r_araddr;
    logic [LEN_W-1:0]    r_arlen;
    logic [2:0]          r_arsize;
    logic [1:0]          r_arburst;

    logic                w_gnt;
    logic [ADDR_W-1:0]   w_addr;
    logic [1:0]          w_dec;

    // Pointer only matters when both masters request; it names the preferred one.
    assign w_gnt  = (ARVALID_M == 2'b11) ? r_ptr : ARVALID_M[1];
    assign w_addr = w_gnt ? ARADDR_M[2*ADDR_W-1:ADDR_W] : ARADDR_M[ADDR_W-1:0];

    always_comb begin
        if ((w_addr & S0_MASK) == S0_BASE)      w_dec = 2'd0;
        else if ((w_addr & S1_MASK) == S1_BASE) w_dec = 2'd1;
        else                                    w_dec = 2'd2;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= 1'b0;
            r_win     <= 1'b0;
            r_sel     <= 2'd0;
            r_arid    <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_arburst <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|ARVALID_M) begin
                        r_win     <= w_gnt;
                        r_ptr     <= ~w_gnt;
                        r_sel     <= w_dec;
                        r_arid    <= {{(IDS_W-IDM_W-1){1'b0}}, w_gnt,
                                      (w_gnt ? ARID_M[2*IDM_W-1:IDM_W] : ARID_M[IDM_W-1:0])};
                        r_araddr  <= w_addr;
                        r_arlen   <= w_gnt ? ARLEN_M[2*LEN_W-1:LEN_W] : ARLEN_M[LEN_W-1:0];
                        r_arsize  <= w_gnt ? ARSIZE_M[5:3] : ARSIZE_M[2:0];
                        r_arburst <= w_gnt ? ARBURST_M[3:2] : ARBURST_M[1:0];
                        r_state   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (ARREADY_S[r_sel]) r_state <= ST_DATA;
                end
                ST_DATA: begin
                    if (RVALID_S[r_sel] && RREADY_M[r_win] && RLAST_S[r_sel]) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ARID_S      = r_arid;
    assign ARADDR_S    = r_araddr;
    assign ARLEN_S     = r_arlen;
    assign ARSIZE_S    = r_arsize;
    assign ARBURST_S   = r_arburst;
    assign o_dbg_state = r_state;

    // Handshakes: a transfer happens on a clock edge where VALID and READY are both 1;
    // the winning master and the selected slave are wired straight through so each side
    // sees the other's VALID/READY in the same cycle, and every other lane is held at 0.
    always_comb begin
        ARVALID_S = '0;
        ARREADY_M = '0;
        RVALID_M  = '0;
        RREADY_S  = '0;
        RID_M     = '0;
        RDATA_M   = '0;
        RRESP_M   = '0;
        RLAST_M   = '0;
        if (r_state == ST_ADDR) begin
            ARVALID_S[r_sel] = 1'b1;
            ARREADY_M[r_win] = ARREADY_S[r_sel];
        end
        if (r_state == ST_DATA) begin
            RVALID_M[r_win]                 = RVALID_S[r_sel];
            RREADY_S[r_sel]                 = RREADY_M[r_win];
            RID_M[r_win*IDM_W +: IDM_W]     = RID_S[r_sel*IDS_W +: IDM_W];
            RDATA_M[r_win*DATA_W +: DATA_W] = RDATA_S[r_sel*DATA_W +: DATA_W];
            RRESP_M[r_win*2 +: 2]           = RRESP_S[r_sel*2 +: 2];
            RLAST_M[r_win]                  = RLAST_S[r_sel];
        end
    end

endmodule

// File: tb/tb_axi_read_router.sv
// Randomized bench for axi_read_router: a request-level model predicts grant order,
// slave selection and returned beats, and a data queue scores every accepted beat.
module tb_axi_read_router;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int IDM_W  = 4;
    localparam int IDS_W  = 8;
    localparam int LEN_W  = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [2*IDM_W-1:0]  ARID_M;
    logic [2*ADDR_W-1:0] ARADDR_M;
    logic [2*LEN_W-1:0]  ARLEN_M;
    logic [5:0]          ARSIZE_M;
    logic [3:0]          ARBURST_M;
    logic [1:0]          ARVALID_M;
    logic [1:0]          ARREADY_M;
    logic [2*IDM_W-1:0]  RID_M;
    logic [2*DATA_W-1:0] RDATA_M;
    logic [3:0]          RRESP_M;
    logic [1:0]          RLAST_M;
    logic [1:0]          RVALID_M;
    logic [1:0]          RREADY_M;
    logic [IDS_W-1:0]    ARID_S;
    logic [ADDR_W-1:0]   ARADDR_S;
    logic [LEN_W-1:0]    ARLEN_S;
    logic [2:0]          ARSIZE_S;
    logic [1:0]          ARBURST_S;
    logic [2:0]          ARVALID_S;
    logic [2:0]          ARREADY_S;
    logic [3*IDS_W-1:0]  RID_S;
    logic [3*DATA_W-1:0] RDATA_S;
    logic [5:0]          RRESP_S;
    logic [2:0]          RLAST_S;
    logic [2:0]          RVALID_S;
    logic [2:0]          RREADY_S;
    logic [1:0]          dbg_state;

    axi_read_router dut (
        .clk(clk), .rst(rst),
        .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
        .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
        .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
        .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
        .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
        .RVALID_S(RVALID_S), .RREADY_S(RREADY_S), .o_dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [DATA_W-1:0] exp_q[$];

    // reference model state
    int          ptr_m;
    bit          pend[2];
    logic [31:0] q_addr[2];
    logic [3:0]  q_len[2];
    logic [3:0]  q_id[2];
    logic [2:0]  q_size[2];
    logic [1:0]  q_burst[2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_slave(input logic [31:0] a);
        if (a < 32'h0001_0000) return 0;
        if (a < 32'h0002_0000) return 1;
        return 2;
    endfunction

    function automatic int ref_winner();
        if (pend[0] && pend[1]) return ptr_m;
        return pend[1] ? 1 : 0;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        case ($urandom_range(0, 2))
            0:       a[31:16] = 16'h0000;
            1:       a[31:16] = 16'h0001;
            default: if (a[31:16] < 16'h0002) a[31] = 1'b1;
        endcase
        return a;
    endfunction

    task automatic new_req(input int m);
        pend[m]    = 1'b1;
        q_addr[m]  = rand_addr();
        q_len[m]   = 4'($urandom_range(0, 3));
        q_id[m]    = 4'($urandom);
        q_size[m]  = 3'($urandom_range(0, 2));
        q_burst[m] = 2'($urandom_range(0, 2));
    endtask

    // driver tasks
    task automatic drive_ar();
        ARVALID_M = {pend[1], pend[0]};
        for (int m = 0; m < 2; m++) begin
            ARID_M[m*IDM_W +: IDM_W]     = q_id[m];
            ARADDR_M[m*ADDR_W +: ADDR_W] = q_addr[m];
            ARLEN_M[m*LEN_W +: LEN_W]    = q_len[m];
            ARSIZE_M[m*3 +: 3]           = q_size[m];
            ARBURST_M[m*2 +: 2]          = q_burst[m];
        end
    endtask

    task automatic clear_slave_side();
        ARREADY_S = '0; RID_S = '0; RDATA_S = '0; RRESP_S = '0;
        RLAST_S = '0; RVALID_S = '0; RREADY_M = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        drive_ar();
        clear_slave_side();
        exp_q.delete();
        tick();
        tick();
        rst = 1'b1;
        ptr_m = 0;
        tick();
    endtask

    // one transaction of master m; abort_at >= 0 drops reset at that beat
    task automatic run_txn(input int m, input int force_stall, input int abort_at);
        int          sel, stall;
        logic [2:0]  r;
        logic [31:0] d;
        logic [1:0]  resp;
        logic        mb;
        sel = ref_slave(q_addr[m]);
        mb  = m[0];
        drive_ar();
        #1;
        check("idle_arready_m", ARREADY_M, 0);
        check("idle_arvalid_s", ARVALID_S, 0);
        check("idle_rvalid_m", RVALID_M, 0);
        tick();
        ptr_m = 1 - m;
        check("ar_valid_s", ARVALID_S, 3'b001 << sel);
        check("ar_id_s", ARID_S, {3'b000, mb, q_id[m]});
        check("ar_addr_s", ARADDR_S, q_addr[m]);
        check("ar_len_s", ARLEN_S, q_len[m]);
        check("ar_size_s", ARSIZE_S, q_size[m]);
        check("ar_burst_s", ARBURST_S, q_burst[m]);
        for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
            r = 3'($urandom);
            r[sel] = 1'b0;
            ARREADY_S = r;
            #1;
            check("ar_wait_ready_m", ARREADY_M, 0);
            check("ar_wait_valid_s", ARVALID_S, 3'b001 << sel);
            tick();
        end
        ARREADY_S = 3'($urandom) | (3'b001 << sel);
        #1;
        check("ar_ready_m", ARREADY_M, 2'b01 << m);
        tick();
        pend[m] = 1'b0;
        drive_ar();
        ARREADY_S = '0;
        for (int b = 0; b <= int'(q_len[m]); b++) begin
            d = $urandom;
            exp_q.push_back(d);
            RVALID_S = 3'($urandom); RDATA_S = {$urandom, $urandom, $urandom};
            RID_S = 24'($urandom); RRESP_S = 6'($urandom); RLAST_S = 3'($urandom);
            resp = (sel == 2) ? 2'b11 : 2'($urandom_range(0, 1));
            RVALID_S[sel]                = 1'b1;
            RDATA_S[sel*DATA_W +: DATA_W] = d;
            RID_S[sel*IDS_W +: IDS_W]    = {4'($urandom), q_id[m]};
            RRESP_S[sel*2 +: 2]          = resp;
            RLAST_S[sel]                 = (b == int'(q_len[m]));
            RREADY_M = 2'b00;
            RREADY_M[1-m] = 1'($urandom);
            if (b == abort_at) begin
                #1;
                rst = 1'b0;
                #1;
                check("rst_arvalid_s", ARVALID_S, 0);
                check("rst_arready_m", ARREADY_M, 0);
                check("rst_rvalid_m", RVALID_M, 0);
                check("rst_rready_s", RREADY_S, 0);
                check("rst_rlast_m", RLAST_M, 0);
                check("rst_rdata_m", RDATA_M, 0);
                check("rst_arid_s", ARID_S, 0);
                exp_q.delete();
                clear_slave_side();
                return;
            end
            stall = (force_stall >= 0) ? force_stall : int'($urandom_range(0, 2));
            for (int s = 0; s < stall; s++) begin
                #1;
                check("stall_rvalid_m", RVALID_M, 2'b01 << m);
                check("stall_rready_s", RREADY_S, 0);
                check("stall_rdata_m", RDATA_M[m*DATA_W +: DATA_W], d);
                check("data_arready_m", ARREADY_M, 0);
                tick();
            end
            RREADY_M[m] = 1'b1;
            #1;
            check("r_rready_s", RREADY_S, 3'b001 << sel);
            check("r_rvalid_m", RVALID_M, 2'b01 << m);
            check("r_rid_m", RID_M[m*IDM_W +: IDM_W], q_id[m]);
            check("r_rresp_m", RRESP_M[m*2 +: 2], resp);
            check("r_rlast_m", RLAST_M, (b == int'(q_len[m])) ? (2'b01 << m) : 2'b00);
            check("r_rdata_m", RDATA_M[m*DATA_W +: DATA_W], exp_q.pop_front());
            check("r_rdata_other", RDATA_M[(1-m)*DATA_W +: DATA_W], 0);
            tick();
        end
        clear_slave_side();
    endtask

    initial begin
        rst = 1'b0;
        ptr_m = 0;
        for (int m = 0; m < 2; m++) begin
            pend[m] = 1'b0; q_addr[m] = '0; q_len[m] = '0;
            q_id[m] = '0; q_size[m] = '0; q_burst[m] = '0;
        end
        drive_ar();
        clear_slave_side();
        #1;
        check("reset_arvalid_s", ARVALID_S, 0);
        check("reset_arready_m", ARREADY_M, 0);
        check("reset_rvalid_m", RVALID_M, 0);
        check("reset_rready_s", RREADY_S, 0);
        check("reset_ar_bus", {ARID_S, ARLEN_S, ARSIZE_S, ARBURST_S}, 0);
        check("reset_araddr_s", ARADDR_S, 0);
        check("reset_r_out", {RID_M, RRESP_M, RLAST_M}, 0);
        #20;
        rst = 1'b1;
        tick();

        // single M0 burst to S0 with sustained master backpressure
        pend[0] = 1'b1; q_addr[0] = 32'h0000_0010; q_len[0] = 4'd3; q_id[0] = 4'h5;
        q_size[0] = 3'd2; q_burst[0] = 2'd1;
        run_txn(0, 3, -1);

        // simultaneous requests straight after reset, then S1 and default-slave routes
        do_reset();
        pend[0] = 1'b1; q_addr[0] = 32'h0000_0100; q_len[0] = 4'd1; q_id[0] = 4'h3;
        pend[1] = 1'b1; q_addr[1] = 32'h0001_0004; q_len[1] = 4'd2; q_id[1] = 4'h7;
        run_txn(ref_winner(), -1, -1);
        run_txn(ref_winner(), -1, -1);
        pend[1] = 1'b1; q_addr[1] = 32'h2000_0000; q_len[1] = 4'd0; q_id[1] = 4'h9;
        run_txn(ref_winner(), -1, -1);

        // random mix; losers keep requesting until granted
        for (int n = 0; n < 40; n++) begin
            for (int m = 0; m < 2; m++)
                if (!pend[m] && ($urandom_range(0, 1) == 1)) new_req(m);
            if (!pend[0] && !pend[1]) new_req(int'($urandom_range(0, 1)));
            run_txn(ref_winner(), -1, -1);
        end

        // reset in the middle of a burst, with the pointer left at M1 beforehand
        do_reset();
        pend[0] = 1'b1; q_addr[0] = 32'h0000_0040; q_len[0] = 4'd3; q_id[0] = 4'hA;
        run_txn(0, 1, 1);
        pend[0] = 1'b0; pend[1] = 1'b0;
        drive_ar();
        tick();
        rst = 1'b1;
        ptr_m = 0;
        tick();
        new_req(0);
        new_req(1);
        run_txn(ref_winner(), -1, -1);
        run_txn(ref_winner(), -1, -1);
        new_req(1);
        run_txn(ref_winner(), -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
